// File: rtl/emaxi_pkg.sv
// emesh packet layout, datamode codes and AXI write constants shared by
// the write bridge and its buffer; also the wstrb/wdata lane helpers.
package emaxi_pkg;

  localparam int WRITE_BIT = 0;
  localparam int DM_LSB    = 1;
  localparam int CTRL_LSB  = 3;
  localparam int DST_LSB   = 8;
  localparam int DATA_LSB  = 40;
  localparam int SRC_LSB   = 72;

  typedef enum logic [1:0] {
    DM_BYTE   = 2'd0,
    DM_HALF   = 2'd1,
    DM_WORD   = 2'd2,
    DM_DOUBLE = 2'd3
  } datamode_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;

  function automatic logic [7:0] wstrb_f(
    input datamode_e  dm,
    input logic [2:0] a
  );
    logic [7:0] s;
    unique case (dm)
      DM_BYTE: s = 8'h01 << a;
      DM_HALF: s = 8'h03 << {a[2:1], 1'b0};
      DM_WORD: s = 8'h0F << {a[2], 2'b00};
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] wdata_f(
    input datamode_e   dm,
    input logic [31:0] d,
    input logic [31:0] s
  );
    logic [63:0] w;
    unique case (dm)
      DM_BYTE: w = {8{d[7:0]}};
      DM_HALF: w = {4{d[15:0]}};
      DM_WORD: w = {d, d};
      default: w = {s, d};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/emaxi_wr_fifo.sv
// DEPTH x PW synchronous write buffer; head is visible from registers,
// so a pushed entry reaches dout_o no earlier than the next cycle.
// Ports: push_i/din_i write, pop_i/dout_o read, full_o/empty_o/count_o status.
module emaxi_wr_fifo #(
  parameter int PW    = 104,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [PW-1:0]              din_i,
  input  logic                       pop_i,
  output logic [PW-1:0]              dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)
      count_d = count_q + 1'b1;
    else if (!push_i && pop_i)
      count_d = count_q - 1'b1;
  end

  // power-of-two depth: pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i)
      mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/emaxi_wr_bridge.sv
// emesh write packets -> single-beat AXI4 AW/W writes, B accounting.
// Ports: wr_* emesh in, m_axi_aw*/w*/b* AXI master, outstanding/err_cnt/err status.
module emaxi_wr_bridge
  import emaxi_pkg::*;
#(
  parameter int PW      = 104,
  parameter int DEPTH   = 4,
  parameter int ID_W    = 4,
  parameter int AXI_ID  = 0,
  parameter int MAX_OUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_access,
  input  logic [PW-1:0]   wr_packet,
  output logic            wr_wait,
  output logic [ID_W-1:0] m_axi_awid,
  output logic [31:0]     m_axi_awaddr,
  output logic [7:0]      m_axi_awlen,
  output logic [2:0]      m_axi_awsize,
  output logic [1:0]      m_axi_awburst,
  output logic            m_axi_awlock,
  output logic [3:0]      m_axi_awcache,
  output logic [2:0]      m_axi_awprot,
  output logic [3:0]      m_axi_awqos,
  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  output logic [ID_W-1:0] m_axi_wid,
  output logic [63:0]     m_axi_wdata,
  output logic [7:0]      m_axi_wstrb,
  output logic            m_axi_wlast,
  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  input  logic [ID_W-1:0] m_axi_bid,
  input  logic [1:0]      m_axi_bresp,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,
  output logic [7:0]      outstanding,
  output logic [7:0]      err_cnt,
  output logic            err
);

  localparam int CW = $clog2(DEPTH+1);

  logic            push, pop, full, empty;
  logic [PW-1:0]   head;
  logic [CW-1:0]   count;
  datamode_e       dm;
  logic [31:0]     dst, dat, src;
  logic            hs_aw, hs_w, aw_fin, w_fin;
  logic            b_take, b_err;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [7:0]      out_q, out_d;
  logic [7:0]      errc_q, errc_d;
  logic            err_q, err_d;

  // read packets are dropped here and never enter the buffer
  assign push    = wr_access & ~full & wr_packet[WRITE_BIT];
  assign wr_wait = full;

  emaxi_wr_fifo #(
    .PW    (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (wr_packet),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign dm  = datamode_e'(head[DM_LSB +: 2]);
  assign dst = head[DST_LSB +: 32];
  assign dat = head[DATA_LSB +: 32];
  assign src = head[SRC_LSB +: 32];

  // valids depend only on registered state, so they hold until handshake;
  // outstanding can only fall while awvalid waits
  assign m_axi_awvalid = ~empty & ~aw_done_q & (out_q < 8'(MAX_OUT));
  assign m_axi_wvalid  = ~empty & ~w_done_q;

  assign hs_aw  = m_axi_awvalid & m_axi_awready;
  assign hs_w   = m_axi_wvalid & m_axi_wready;
  assign aw_fin = aw_done_q | hs_aw;
  assign w_fin  = w_done_q | hs_w;
  assign pop    = ~empty & aw_fin & w_fin;

  assign m_axi_bready = ~rst;
  assign b_take = m_axi_bvalid & m_axi_bready & (out_q != 8'd0);
  assign b_err  = m_axi_bvalid & m_axi_bready & (m_axi_bresp != 2'b00);

  always_comb begin
    aw_done_d = aw_fin;
    w_done_d  = w_fin;
    if (pop) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
    out_d = out_q;
    if (hs_aw && !b_take)
      out_d = out_q + 8'd1;
    else if (!hs_aw && b_take)
      out_d = out_q - 8'd1;
    errc_d = errc_q;
    if (b_err && errc_q != 8'hFF)
      errc_d = errc_q + 8'd1;
    err_d = err_q | b_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      out_q     <= '0;
      errc_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      out_q     <= out_d;
      errc_q    <= errc_d;
      err_q     <= err_d;
    end
  end

  assign m_axi_awid    = ID_W'(AXI_ID);
  assign m_axi_awaddr  = dst;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = {1'b0, dm};
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_MOD;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;

  assign m_axi_wid   = ID_W'(AXI_ID);
  assign m_axi_wdata = wdata_f(dm, dat, src);
  assign m_axi_wstrb = wstrb_f(dm, dst[2:0]);
  assign m_axi_wlast = 1'b1;

  assign outstanding = out_q;
  assign err_cnt     = errc_q;
  assign err         = err_q;

  logic unused_ok;
  assign unused_ok = ^{head[CTRL_LSB +: 5], head[WRITE_BIT], m_axi_bid, count};

endmodule

// File: tb/tb_emaxi_wr_bridge.sv
// Directed bench for emaxi_wr_bridge: payload vector table plus
// backpressure, channel skew, MAX_OUT, error and reset sequences.
module tb_emaxi_wr_bridge;

  localparam int PW      = 104;
  localparam int DEPTH   = 4;
  localparam int ID_W    = 4;
  localparam int AXI_ID  = 3;
  localparam int MAX_OUT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_access;
  logic [PW-1:0]   wr_packet;
  logic            wr_wait;
  logic [ID_W-1:0] m_axi_awid;
  logic [31:0]     m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awlock;
  logic [3:0]      m_axi_awcache;
  logic [2:0]      m_axi_awprot;
  logic [3:0]      m_axi_awqos;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [ID_W-1:0] m_axi_wid;
  logic [63:0]     m_axi_wdata;
  logic [7:0]      m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [ID_W-1:0] m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;
  logic [7:0]      outstanding;
  logic [7:0]      err_cnt;
  logic            err;

  always #5 clk = ~clk;

  emaxi_wr_bridge #(
    .PW      (PW),
    .DEPTH   (DEPTH),
    .ID_W    (ID_W),
    .AXI_ID  (AXI_ID),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_access     (wr_access),
    .wr_packet     (wr_packet),
    .wr_wait       (wr_wait),
    .m_axi_awid    (m_axi_awid),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awlock  (m_axi_awlock),
    .m_axi_awcache (m_axi_awcache),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awqos   (m_axi_awqos),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wid     (m_axi_wid),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bid     (m_axi_bid),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .outstanding   (outstanding),
    .err_cnt       (err_cnt),
    .err           (err)
  );

  int checks = 0;
  int errors = 0;
  int aw_hs;

  typedef struct {
    logic [1:0]  dm;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] src;
    logic [7:0]  strb;
    logic [63:0] wd;
  } vec_t;

  vec_t vt[6];

  logic [PW-1:0] pend[$];
  logic [31:0]   expq[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [1:0] dm,
    input logic [31:0] a, input logic [31:0] d, input logic [31:0] s,
    input logic wr);
    return {s, d, a, 5'd0, dm, wr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic qpkt(input logic [31:0] a);
    pend.push_back(mk(2'd2, a, a ^ 32'h5555_0000, 32'd0, 1'b1));
    expq.push_back(a);
  endtask

  // drives queued packets as wr_wait allows, checks AW order on handshakes
  task automatic run(input int n);
    logic acc;
    for (int c = 0; c < n; c++) begin
      if (pend.size() > 0) begin
        wr_access = 1'b1;
        wr_packet = pend[0];
      end else begin
        wr_access = 1'b0;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        aw_hs++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL aw_extra actual=%h required=none", m_axi_awaddr);
        end else begin
          chk("aw_order", 64'(m_axi_awaddr), 64'(expq.pop_front()));
        end
      end
      acc = wr_access && !wr_wait;
      tick();
      if (acc)
        void'(pend.pop_front());
    end
    wr_access = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{2'd2, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,
              8'hF0, 64'hDEADBEEF_DEADBEEF};
    vt[1] = '{2'd0, 32'h0000_0103, 32'h0000_005A, 32'h0,
              8'h08, 64'h5A5A5A5A_5A5A5A5A};
    vt[2] = '{2'd1, 32'h0000_0006, 32'h1234_ABCD, 32'h0,
              8'hC0, 64'hABCDABCD_ABCDABCD};
    vt[3] = '{2'd3, 32'h0000_1000, 32'h1122_3344, 32'hCAFE_F00D,
              8'hFF, 64'hCAFEF00D_11223344};
    vt[4] = '{2'd2, 32'h0000_0000, 32'h0102_0304, 32'h0,
              8'h0F, 64'h01020304_01020304};
    vt[5] = '{2'd0, 32'h0000_0007, 32'hFFEE_DD99, 32'h0,
              8'h80, 64'h99999999_99999999};

    rst = 1'b1;
    wr_access = 1'b0;
    wr_packet = '0;
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    m_axi_bid = '0;
    m_axi_bresp = 2'b00;
    m_axi_bvalid = 1'b0;
    tick();
    tick();
    chk("rst_bready", 64'(m_axi_bready), 64'd0);
    chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("rst_wr_wait", 64'(wr_wait), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    tick();
    chk("bready_run", 64'(m_axi_bready), 64'd1);

    // payload table
    for (int i = 0; i < 6; i++) begin
      wr_access = 1'b1;
      wr_packet = mk(vt[i].dm, vt[i].addr, vt[i].data, vt[i].src, 1'b1);
      tick();
      wr_access = 1'b0;
      chk("tbl_awvalid", 64'(m_axi_awvalid), 64'd1);
      chk("tbl_wvalid", 64'(m_axi_wvalid), 64'd1);
      chk("tbl_awaddr", 64'(m_axi_awaddr), 64'(vt[i].addr));
      chk("tbl_awsize", 64'(m_axi_awsize), 64'({1'b0, vt[i].dm}));
      chk("tbl_wstrb", 64'(m_axi_wstrb), 64'(vt[i].strb));
      chk("tbl_wdata", m_axi_wdata, vt[i].wd);
      chk("tbl_fixed",
          64'({m_axi_awlen, m_axi_awburst, m_axi_awlock, m_axi_awcache,
               m_axi_awprot, m_axi_awqos, m_axi_wlast}),
          64'({8'd0, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b1}));
      chk("tbl_ids", 64'({m_axi_awid, m_axi_wid}), 64'({4'd3, 4'd3}));
      m_axi_awready = 1'b1;
      m_axi_wready = 1'b1;
      tick();
      m_axi_awready = 1'b0;
      m_axi_wready = 1'b0;
      chk("tbl_popped", 64'({m_axi_awvalid, m_axi_wvalid}), 64'd0);
      chk("tbl_out_inc", 64'(outstanding), 64'd1);
      m_axi_bvalid = 1'b1;
      tick();
      m_axi_bvalid = 1'b0;
      chk("tbl_out_dec", 64'(outstanding), 64'd0);
    end

    // read packet is dropped
    wr_access = 1'b1;
    wr_packet = mk(2'd2, 32'h40, 32'h1, 32'h0, 1'b0);
    tick();
    wr_access = 1'b0;
    chk("drop_awvalid", 64'(m_axi_awvalid), 64'd0);
    tick();
    chk("drop_wvalid", 64'(m_axi_wvalid), 64'd0);

    // fill to full, hold fifth, then drain in order
    for (int i = 0; i < 5; i++)
      qpkt(32'h200 + 32'(i * 8));
    aw_hs = 0;
    run(4);
    chk("full_wait", 64'(wr_wait), 64'd1);
    chk("full_pend", 64'(pend.size()), 64'd1);
    pend.push_front(pend.pop_front());
    run(2);
    chk("full_held", 64'(pend.size()), 64'd1);
    chk("full_head", 64'(m_axi_awaddr), 64'h200);
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    m_axi_bvalid = 1'b1;
    run(12);
    chk("drain_hs", 64'(aw_hs), 64'd5);
    chk("drain_left", 64'(expq.size()), 64'd0);
    chk("drain_out", 64'(outstanding), 64'd0);
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0;

    // W completes first, AW three cycles later
    m_axi_wready = 1'b1;
    wr_access = 1'b1;
    wr_packet = mk(2'd2, 32'h300, 32'h3, 32'h0, 1'b1);
    tick();
    wr_access = 1'b0;
    chk("skew_both", 64'({m_axi_awvalid, m_axi_wvalid}), 64'b11);
    tick();
    chk("skew_wdrop", 64'(m_axi_wvalid), 64'd0);
    chk("skew_awhold", 64'(m_axi_awvalid), 64'd1);
    tick();
    tick();
    chk("skew_awstable", 64'({m_axi_awvalid, m_axi_awaddr}), {31'd0, 1'b1, 32'h300});
    chk("skew_wstill", 64'(m_axi_wvalid), 64'd0);
    m_axi_wready = 1'b0;
    m_axi_awready = 1'b1;
    tick();
    m_axi_awready = 1'b0;
    chk("skew_pop", 64'({m_axi_awvalid, m_axi_wvalid}), 64'd0);
    chk("skew_out", 64'(outstanding), 64'd1);
    wr_access = 1'b1;
    wr_packet = mk(2'd2, 32'h308, 32'h4, 32'h0, 1'b1);
    tick();
    wr_access = 1'b0;
    chk("skew_next", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_awaddr}),
        {30'd0, 2'b11, 32'h308});
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    tick();
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    chk("skew_out2", 64'(outstanding), 64'd2);
    m_axi_bvalid = 1'b1;
    tick();
    tick();
    m_axi_bvalid = 1'b0;
    chk("skew_clr", 64'(outstanding), 64'd0);

    // MAX_OUT limit
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    for (int i = 0; i < 4; i++)
      qpkt(32'h400 + 32'(i * 8));
    aw_hs = 0;
    run(12);
    chk("mo_hs", 64'(aw_hs), 64'd2);
    chk("mo_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("mo_out", 64'(outstanding), 64'd2);
    m_axi_bvalid = 1'b1;
    run(2);
    m_axi_bvalid = 1'b0;
    run(10);
    chk("mo_hs2", 64'(aw_hs), 64'd4);
    chk("mo_left", 64'(expq.size()), 64'd0);
    chk("mo_out2", 64'(outstanding), 64'd2);
    m_axi_bvalid = 1'b1;
    tick();
    tick();
    m_axi_bvalid = 1'b0;
    chk("mo_clr", 64'(outstanding), 64'd0);

    // error responses
    m_axi_bvalid = 1'b1;
    m_axi_bresp = 2'b10;
    tick();
    m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00;
    chk("err_flag", 64'(err), 64'd1);
    chk("err_cnt1", 64'(err_cnt), 64'd1);
    tick();
    chk("err_sticky", 64'(err), 64'd1);
    chk("err_out", 64'(outstanding), 64'd0);

    // reset with buffered entries
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    for (int i = 0; i < 3; i++)
      qpkt(32'h600 + 32'(i * 8));
    run(3);
    chk("pre_rst_awvalid", 64'(m_axi_awvalid), 64'd1);
    pend.delete();
    expq.delete();
    rst = 1'b1;
    tick();
    chk("mid_rst_bready", 64'(m_axi_bready), 64'd0);
    chk("mid_rst_valids", 64'({m_axi_awvalid, m_axi_wvalid}), 64'd0);
    rst = 1'b0;
    chk("post_rst_state", 64'({wr_wait, err, outstanding, err_cnt}), 64'd0);
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    qpkt(32'h500);
    aw_hs = 0;
    run(4);
    chk("post_rst_hs", 64'(aw_hs), 64'd1);
    chk("post_rst_left", 64'(expq.size()), 64'd0);
    chk("post_rst_out", 64'(outstanding), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
